// File: rtl/sign_reduction.sv
// Two-stage valid/ready pipeline that reduces a signed IN_W word to a signed OUT_W field.
// Optional macro SIGN_REDUCTION_SAT_EN: saturate non-fitting words instead of truncating them.
module sign_reduction #(
  parameter int IN_W  = 8,
  parameter int OUT_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IN_W-1:0]  in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [OUT_W-1:0] out_bits,
  output logic             out_fits,
  output logic             out_valid,
  input  logic             out_ready,
  input  logic             clr_cnt,
  output logic [7:0]       ovf_cnt
);

  logic [IN_W-1:0]  r_s1_data;
  logic             r_s1_valid;
  logic [OUT_W-1:0] r_s2_bits;
  logic             r_s2_fits;
  logic             r_s2_valid;
  logic [7:0]       r_ovf_cnt;

  logic             w_in_xfer;
  logic             w_s2_load;
  logic             w_s1_fits;
  logic [OUT_W-1:0] w_s1_bits;

  // Word fits when every bit from the MSB down to the new sign position agrees.
  function automatic logic fits_f(input logic [IN_W-1:0] d);
    logic [IN_W-OUT_W:0] top;
    top = d[IN_W-1:OUT_W-1];
    return (&top) | ~(|top);
  endfunction

`ifdef SIGN_REDUCTION_SAT_EN
  function automatic logic [OUT_W-1:0] sat_f(input logic neg);
    logic [OUT_W-1:0] v;
    if (neg) begin
      v = {1'b1, {(OUT_W-1){1'b0}}};
    end else begin
      v = {1'b0, {(OUT_W-1){1'b1}}};
    end
    return v;
  endfunction
`endif

  // Handshake decode: S2 frees up when empty or drained this edge.
  always_comb begin
    in_ready  = ~r_s1_valid | ~r_s2_valid | out_ready;
    w_in_xfer = in_valid & in_ready;
    w_s2_load = r_s1_valid & (~r_s2_valid | out_ready);
  end

  // Reduction of the S1 word into the S2 result.
  always_comb begin
    w_s1_fits = fits_f(r_s1_data);
`ifdef SIGN_REDUCTION_SAT_EN
    if (w_s1_fits) begin
      w_s1_bits = r_s1_data[OUT_W-1:0];
    end else begin
      w_s1_bits = sat_f(r_s1_data[IN_W-1]);
    end
`else
    w_s1_bits = r_s1_data[OUT_W-1:0];
`endif
  end

  // Pipeline stages S1 and S2.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_data  <= {IN_W{1'b0}};
      r_s1_valid <= 1'b0;
      r_s2_bits  <= {OUT_W{1'b0}};
      r_s2_fits  <= 1'b0;
      r_s2_valid <= 1'b0;
    end else begin
      if (w_s2_load) begin
        r_s2_bits  <= w_s1_bits;
        r_s2_fits  <= w_s1_fits;
        r_s2_valid <= 1'b1;
      end else if (out_ready) begin
        r_s2_valid <= 1'b0;
      end else begin
        r_s2_valid <= r_s2_valid;
      end

      if (w_in_xfer) begin
        r_s1_data  <= in_data;
        r_s1_valid <= 1'b1;
      end else if (w_s2_load) begin
        r_s1_valid <= 1'b0;
      end else begin
        r_s1_valid <= r_s1_valid;
      end
    end
  end

  // Saturating overflow counter; clear beats a simultaneous increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf_cnt <= 8'd0;
    end else if (clr_cnt) begin
      r_ovf_cnt <= 8'd0;
    end else if (w_s2_load && !w_s1_fits && (r_ovf_cnt != 8'hFF)) begin
      r_ovf_cnt <= r_ovf_cnt + 8'd1;
    end else begin
      r_ovf_cnt <= r_ovf_cnt;
    end
  end

  assign out_bits  = r_s2_bits;
  assign out_fits  = r_s2_fits;
  assign out_valid = r_s2_valid;
  assign ovf_cnt   = r_ovf_cnt;

endmodule
